// File: rtl/param_core_pkg.sv
// -----------------------------------------------------------------------------
// param_core_pkg
// Shared definitions for the configurable processing core:
//   - per-channel configuration word layout (enable bit + 3-bit op code)
//   - op code values
//   - configuration-load FSM state encoding
//   - small helpers to pick fields out of a channel configuration word
// No ports (package).
// -----------------------------------------------------------------------------
package param_core_pkg;

    // Configuration bits per channel: [3] = channel enable, [2:0] = op.
    localparam int CFG_BITS   = 4;
    localparam int CFG_EN_BIT = 3;

    // Operation codes (results are modulo 2^W).
    localparam logic [2:0] OP_PASS_A = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_AND    = 3'd3;
    localparam logic [2:0] OP_OR     = 3'd4;
    localparam logic [2:0] OP_XOR    = 3'd5;
    localparam logic [2:0] OP_ACC    = 3'd6;
    localparam logic [2:0] OP_MAX    = 3'd7;

    // Configuration-load FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Field extraction helpers for one channel configuration word.
    function automatic logic [2:0] cfg_op(input logic [CFG_BITS-1:0] cfg);
        return cfg[2:0];
    endfunction

    function automatic logic cfg_en(input logic [CFG_BITS-1:0] cfg);
        return cfg[CFG_EN_BIT];
    endfunction

endpackage : param_core_pkg

// File: rtl/param_core_channel.sv
// -----------------------------------------------------------------------------
// core_channel
// One processing lane of param_core. Applies the configured op to operands
// a and b and registers the result (1-cycle latency). The output register
// only updates when the operands are valid and the lane is enabled; in all
// other cycles it holds, which is also what gives ACC its running state.
//
// Ports:
//   clb_clk   in   1         clock, rising edge
//   clb_rst   in   1         synchronous reset, active-high (clears result)
//   cfg       in   CFG_BITS  active lane config: [3]=enable, [2:0]=op
//   a         in   W         operand A
//   b         in   W         operand B
//   in_valid  in   1         operands valid this cycle
//   out       out  W         registered result
// -----------------------------------------------------------------------------
module core_channel
    import param_core_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clb_clk,
    input  logic                clb_rst,
    input  logic [CFG_BITS-1:0] cfg,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    input  logic                in_valid,
    output logic [W-1:0]        out
);

    logic [W-1:0] out_q;
    logic [W-1:0] out_d;
    logic [W-1:0] result;

    // Op result; all arithmetic wraps at W bits (carry/borrow dropped).
    always_comb begin
        result = '0;
        case (cfg_op(cfg))
            OP_PASS_A: result = a;
            OP_ADD:    result = a + b;
            OP_SUB:    result = a - b;
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_ACC:    result = out_q + a;   // accumulates onto the held result
            OP_MAX:    result = (a > b) ? a : b;
        endcase
    end

    always_comb begin
        out_d = out_q;
        if (in_valid && cfg_en(cfg)) begin
            out_d = result;
        end
    end

    always_ff @(posedge clb_clk) begin
        if (clb_rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : core_channel

// File: rtl/param_core.sv
// -----------------------------------------------------------------------------
// param_core
// N-channel configurable processing core. Channel configuration is shifted
// in serially (MSB first) through a scan chain and committed atomically into
// the active configuration only when exactly N_CH*CFG_BITS bits were shifted.
// The datapath keeps running on the old active configuration while a new
// one is being shifted in.
//
// Ports:
//   clb_clk    in   1        clock, rising edge
//   clb_rst    in   1        synchronous reset, active-high
//   prog_in    in   1        serial config data, sampled when prog_en=1
//   prog_en    in   1        shift enable for the config chain
//   prog_out   out  1        chain MSB, for daisy-chaining to the next core
//   cfg_done   out  1        pulse: new configuration committed
//   cfg_err    out  1        pulse: wrong bit count, commit rejected
//   in_valid   in   1        operands valid this cycle
//   in_a       in   N_CH*W   operand A, channel k at [k*W +: W]
//   in_b       in   N_CH*W   operand B, channel k at [k*W +: W]
//   out_valid  out  1        in_valid delayed by one cycle
//   out_data   out  N_CH*W   results, channel k at [k*W +: W]
// -----------------------------------------------------------------------------
module param_core
    import param_core_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 32
) (
    input  logic              clb_clk,
    input  logic              clb_rst,
    input  logic              prog_in,
    input  logic              prog_en,
    output logic              prog_out,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic              in_valid,
    input  logic [N_CH*W-1:0] in_a,
    input  logic [N_CH*W-1:0] in_b,
    output logic              out_valid,
    output logic [N_CH*W-1:0] out_data
);

    localparam int L  = N_CH * CFG_BITS;
    // Counter must reach L+1 so an over-long load is distinguishable from L.
    localparam int CW = $clog2(L + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(L);
    localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

    logic [L-1:0]  chain_q, chain_d;
    logic [L-1:0]  active_cfg_q, active_cfg_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic          out_valid_q, out_valid_d;

    // Next-state logic for the configuration chain and load FSM. The
    // done/err pulses are decoded from the registered state, so they are
    // high for exactly the one COMMIT cycle.
    always_comb begin
        chain_d      = chain_q;
        active_cfg_d = active_cfg_q;
        count_d      = count_q;
        state_d      = state_q;
        cfg_done     = 1'b0;
        cfg_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (prog_en) begin
                    chain_d = {chain_q[L-2:0], prog_in};
                    count_d = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (prog_en) begin
                    chain_d = {chain_q[L-2:0], prog_in};
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // prog_en is deliberately ignored here: no shift this cycle.
                if (count_q == CNT_FULL) begin
                    active_cfg_d = chain_q;
                    cfg_done     = 1'b1;
                end else begin
                    cfg_err      = 1'b1;
                end
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = in_valid;
    end

    always_ff @(posedge clb_clk) begin
        if (clb_rst) begin
            chain_q      <= '0;
            active_cfg_q <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
        end else begin
            chain_q      <= chain_d;
            active_cfg_q <= active_cfg_d;
            count_q      <= count_d;
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign prog_out  = chain_q[L-1];
    assign out_valid = out_valid_q;

    // One lane per channel; each sees its own slice of the active config.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            core_channel #(
                .W (W)
            ) u_ch (
                .clb_clk  (clb_clk),
                .clb_rst  (clb_rst),
                .cfg      (active_cfg_q[gi*CFG_BITS +: CFG_BITS]),
                .a        (in_a[gi*W +: W]),
                .b        (in_b[gi*W +: W]),
                .in_valid (in_valid),
                .out      (out_data[gi*W +: W])
            );
        end
    endgenerate

endmodule : param_core

// File: tb/tb_param_core.sv
module tb_param_core;
    import param_core_pkg::*;

    localparam int N_CH = 4;
    localparam int W    = 32;
    localparam int L    = N_CH * CFG_BITS;

    logic              clb_clk = 1'b0;
    logic              clb_rst;
    logic              prog_in;
    logic              prog_en;
    logic              prog_out;
    logic              cfg_done;
    logic              cfg_err;
    logic              in_valid;
    logic [N_CH*W-1:0] in_a;
    logic [N_CH*W-1:0] in_b;
    logic              out_valid;
    logic [N_CH*W-1:0] out_data;

    param_core #(.N_CH(N_CH), .W(W)) dut (
        .clb_clk   (clb_clk),
        .clb_rst   (clb_rst),
        .prog_in   (prog_in),
        .prog_en   (prog_en),
        .prog_out  (prog_out),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clb_clk = ~clb_clk;

    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_txn    = 0;
    logic [N_CH*W-1:0] exp_q[$];
    logic [W-1:0]      exp_vec[N_CH];
    bit                acc_stream = 1'b0;
    bit                hist[$];

    task automatic check(input string name, input logic [N_CH*W-1:0] act,
                         input logic [N_CH*W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    function automatic logic [N_CH*W-1:0] pack_exp();
        return {exp_vec[3], exp_vec[2], exp_vec[1], exp_vec[0]};
    endfunction

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        in_a = {N_CH{a}};
        in_b = {N_CH{b}};
    endtask

    // One clock. If operands are valid, the expected result for this edge
    // (set up by the caller in exp_vec) is queued for the monitor.
    task automatic tick();
        if (in_valid) begin
            if (acc_stream) exp_vec[0] = exp_vec[0] + 32'd1;
            exp_q.push_back(pack_exp());
        end
        @(posedge clb_clk);
        #1;
    endtask

    // Shift the low nbits of word MSB first, then let the FSM commit.
    task automatic load(input logic [15:0] word, input int nbits, input bit expect_ok);
        bit exp_po;
        for (int i = nbits - 1; i >= 0; i--) begin
            prog_en = 1'b1;
            prog_in = word[i];
            hist.push_back(word[i]);
            tick();
            exp_po = (hist.size() >= L) ? hist[hist.size() - L] : 1'b0;
            check("prog_out", prog_out, exp_po);
        end
        prog_en = 1'b0;
        prog_in = 1'b0;
        tick();                      // FSM now in COMMIT
        check("cfg_done_commit", cfg_done, expect_ok);
        check("cfg_err_commit", cfg_err, !expect_ok);
        tick();                      // back in IDLE, pulse must be gone
        check("cfg_done_after", cfg_done, 1'b0);
        check("cfg_err_after", cfg_err, 1'b0);
    endtask

    // Monitor: every presented result is matched against the queue head.
    always @(negedge clb_clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL out_valid: got 1, want 0 (no transaction pending)");
            end else begin
                logic [N_CH*W-1:0] e;
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: out_data=%h expected=%h", n_txn, out_data, e);
                check("out_data", out_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clb_rst  = 1'b1;
        prog_en  = 1'b0;
        prog_in  = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        for (int k = 0; k < N_CH; k++) exp_vec[k] = '0;
        tick();
        tick();
        clb_rst = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_prog_out", prog_out, 1'b0);

        // 1: no config -> all channels disabled, outputs stay 0
        set_ops(32'd5, 32'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_out_valid_hi", out_valid, 1'b1);
        tick();
        check("t1_out_valid_lo", out_valid, 1'b0);

        // 2: ch0 ADD, ch1 SUB, ch2 XOR, ch3 MAX, all enabled
        load(16'hFDA9, 16, 1'b1);
        set_ops(32'd5, 32'd3);
        exp_vec[0] = 32'd8; exp_vec[1] = 32'd2; exp_vec[2] = 32'd6; exp_vec[3] = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();

        // 3: short load rejected, old config still in use
        load(16'h0001, 15, 1'b0);
        set_ops(32'd7, 32'd2);
        exp_vec[0] = 32'd9; exp_vec[1] = 32'd5; exp_vec[2] = 32'd5; exp_vec[3] = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();

        // 4: wrap-around; disabled channels hold 9,5,5,7
        load(16'h000A, 16, 1'b1);
        set_ops(32'd0, 32'd1);
        exp_vec[0] = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        load(16'h0009, 16, 1'b1);
        set_ops(32'hFFFF_FFFF, 32'd1);
        exp_vec[0] = 32'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();

        // 5: ACC 1..10, then switch to ADD while streaming
        load(16'h000E, 16, 1'b1);
        set_ops(32'd1, 32'd100);
        in_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            exp_vec[0] = 32'(k);
            tick();
        end
        acc_stream = 1'b1;           // 18 more ACC edges during the load: 11..28
        load(16'h0009, 16, 1'b1);
        acc_stream = 1'b0;
        exp_vec[0] = 32'd101;        // first edge after COMMIT uses ADD
        tick();
        tick();
        in_valid = 1'b0;
        tick();

        // 6: reset mid-shift aborts the load
        for (int k = 0; k < 8; k++) begin
            prog_en = 1'b1;
            prog_in = 1'b1;
            tick();
        end
        clb_rst = 1'b1;
        prog_en = 1'b0;
        prog_in = 1'b0;
        tick();
        clb_rst = 1'b0;
        hist.delete();
        for (int k = 0; k < N_CH; k++) exp_vec[k] = '0;
        check("t6_cfg_done", cfg_done, 1'b0);
        check("t6_cfg_err", cfg_err, 1'b0);
        check("t6_out_data", out_data, '0);
        check("t6_prog_out", prog_out, 1'b0);
        tick();
        check("t6_cfg_done_next", cfg_done, 1'b0);
        check("t6_cfg_err_next", cfg_err, 1'b0);
        set_ops(32'd5, 32'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        // second load scans out the first load's bits on prog_out
        load(16'hFDA9, 16, 1'b1);
        load(16'h9ABC, 16, 1'b1);
        set_ops(32'd5, 32'd3);
        exp_vec[0] = 32'd7; exp_vec[1] = 32'd1; exp_vec[2] = 32'd2; exp_vec[3] = 32'd8;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_param_core
